// File: rtl/onehot_pulse_decoder.sv
// Handshaked binary-index to one-hot strobe decoder; each accepted line is held HOLD cycles.
// Build option THERMO_OUT_EN: load a thermometer code (bits [idx:0]) instead of one-hot.
module onehot_pulse_decoder #(
  parameter int N    = 8,
  parameter int M    = $clog2(N),
  parameter int HOLD = 4,
  parameter int CW   = $clog2(HOLD + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [M-1:0] in_idx,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [N-1:0] out,
  output logic         out_valid,
  output logic         busy,
  output logic         err
);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  localparam logic [M:0] NLIM = (M + 1)'(N);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          accept;
  logic          in_range;

  function automatic logic [N-1:0] decode(input logic [M-1:0] idx);
    logic [N-1:0] d;
    for (int i = 0; i < N; i++) begin
`ifdef THERMO_OUT_EN
      d[i] = ((M + 1)'(i) <= {1'b0, idx});
`else
      d[i] = ((M + 1)'(i) == {1'b0, idx});
`endif
    end
    return d;
  endfunction

  // Ready depends only on state/counter so upstream may gate valid on ready.
  assign in_ready = (state == IDLE) || ((state == ACTIVE) && (cnt == CW'(1)));
  assign busy     = (state == ACTIVE);
  assign accept   = in_valid && in_ready;
  assign in_range = ({1'b0, in_idx} < NLIM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      err <= accept && !in_range;
      case (state)
        IDLE: begin
          if (accept && in_range) begin
            out       <= decode(in_idx);
            out_valid <= 1'b1;
            cnt       <= CW'(HOLD);
            state     <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (cnt > CW'(1)) begin
            cnt <= cnt - CW'(1);
          end else if (accept && in_range) begin
            // Gapless reload: the line may switch in a single edge.
            out       <= decode(in_idx);
            out_valid <= 1'b1;
            cnt       <= CW'(HOLD);
          end else begin
            out       <= '0;
            out_valid <= 1'b0;
            cnt       <= '0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_onehot_pulse_decoder.sv
// Randomized bench for onehot_pulse_decoder: three configurations (N=8/HOLD=4, N=6/HOLD=4, N=8/HOLD=1)
// run side by side against a pulse-schedule reference model.
module tb_onehot_pulse_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       vld [3];
  logic [2:0] idx [3];

  logic [7:0] out0, out2;
  logic [5:0] out1;
  logic       rdy [3];
  logic       ov  [3];
  logic       bsy [3];
  logic       er  [3];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: cycles left on the current pulse, its index, and the err pulse.
  int nn [3] = '{8, 6, 8};
  int hh [3] = '{4, 4, 1};
  int rem [3];
  int cur [3];
  bit errx [3];

  always #5 clk = ~clk;

  onehot_pulse_decoder #(.N(8), .HOLD(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_idx(idx[0]), .in_valid(vld[0]), .in_ready(rdy[0]),
    .out(out0), .out_valid(ov[0]), .busy(bsy[0]), .err(er[0]));

  onehot_pulse_decoder #(.N(6), .HOLD(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_idx(idx[1]), .in_valid(vld[1]), .in_ready(rdy[1]),
    .out(out1), .out_valid(ov[1]), .busy(bsy[1]), .err(er[1]));

  onehot_pulse_decoder #(.N(8), .HOLD(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_idx(idx[2]), .in_valid(vld[2]), .in_ready(rdy[2]),
    .out(out2), .out_valid(ov[2]), .busy(bsy[2]), .err(er[2]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] pat(input int i);
`ifdef THERMO_OUT_EN
    return 8'((1 << (i + 1)) - 1);
`else
    return 8'(1 << i);
`endif
  endfunction

  function automatic logic [7:0] exp_out(input int k);
    return (rem[k] > 0) ? pat(cur[k]) : 8'h00;
  endfunction

  task automatic model_edge();
    for (int k = 0; k < 3; k++) begin
      bit acc;
      acc = vld[k] && (rem[k] <= 1);
      if (acc && (int'(idx[k]) < nn[k])) begin
        rem[k]  = hh[k];
        cur[k]  = int'(idx[k]);
        errx[k] = 1'b0;
      end else if (acc) begin
        rem[k]  = 0;
        errx[k] = 1'b1;
      end else begin
        if (rem[k] > 0) rem[k]--;
        errx[k] = 1'b0;
      end
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      rem[k] = 0; cur[k] = 0; errx[k] = 1'b0;
    end
  endtask

  task automatic check_all();
    logic [7:0] got [3];
    got[0] = out0; got[1] = {2'b00, out1}; got[2] = out2;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("d%0d.out", k), 32'(got[k]), 32'(exp_out(k)));
      chk($sformatf("d%0d.out_valid", k), 32'(ov[k]), 32'(rem[k] > 0));
      chk($sformatf("d%0d.busy", k), 32'(bsy[k]), 32'(rem[k] > 0));
      chk($sformatf("d%0d.in_ready", k), 32'(rdy[k]), 32'(rem[k] <= 1));
      chk($sformatf("d%0d.err", k), 32'(er[k]), 32'(errx[k]));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      vld[k] = 1'b1;
      idx[k] = 3'd3;
    end
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all();
    chk("reset.out0", 32'(out0), 32'h0);
    chk("reset.ready0", 32'(rdy[0]), 32'h1);
    rst_n = 1'b1;

    // First edge after release accepts idx=3 and holds it HOLD cycles.
    for (int c = 0; c < 4; c++) begin
      step();
      chk("post_reset.out0", 32'(out0), 32'(pat(3)));
    end
    for (int k = 0; k < 3; k++) vld[k] = 1'b0;
    step();
    chk("post_reset.idle0", 32'(out0), 32'h0);

    // Directed HOLD=1 run: a new index each cycle with valid held high.
    vld[2] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      idx[2] = 3'(i);
      step();
      chk("hold1.out", 32'(out2), 32'(pat(i)));
      chk("hold1.ready", 32'(rdy[2]), 32'h1);
    end
    vld[2] = 1'b0;
    step();
    chk("hold1.clear", 32'(out2), 32'h0);

    // Directed out-of-range on N=6 from IDLE.
    vld[1] = 1'b1; idx[1] = 3'd7;
    step();
    chk("oor.err", 32'(er[1]), 32'h1);
    chk("oor.out", 32'(out1), 32'h0);
    vld[1] = 1'b0;
    step();

    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < 3; k++) begin
        vld[k] = ($urandom_range(0, 9) < 7);
        idx[k] = 3'($urandom_range(0, 7));
      end
      if ($urandom_range(0, 99) == 0) begin
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        rst_n = 1'b1;
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/onehot_pulse_decoder.md
Name: onehot_pulse_decoder

Overview:
- Sequential counterpart of the codebase's N-input priority encoder. Accepts a binary index with a valid/ready handshake and drives the matching one-hot line for a fixed number of cycles.
- Used wherever an encoded index, such as an arbiter grant or interrupt ID, must be turned back into a per-line strobe of defined width.
- Back-to-back transfers are supported with no idle gap.

Parameters:
- N, 8, number of output lines (>=2).
- M, $clog2(N), index width.
- HOLD, 4, cycles each decoded line stays asserted (>=1).
- CW, $clog2(HOLD+1), hold-counter width (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_idx  input  M  binary index to decode.
- in_valid  input  1  in_idx is valid.
- in_ready  output  1  block can accept this cycle (combinational from state/counter only, never from in_valid).
- out  output  N  decoded one-hot lines, registered.
- out_valid  output  1  out is carrying a decoded index, registered.
- busy  output  1  state == ACTIVE, registered state.
- err  output  1  one-cycle pulse: an accepted index was >= N, registered.

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, cnt=0, out=0, out_valid=0, err=0. busy and in_ready follow from state (busy=0, in_ready=1).
- Reset mid-operation: asserting rst_n low clears everything immediately, with no clock edge needed. The first post-reset edge with in_valid=1 is accepted normally.
- Accept: transfer occurs on a rising edge where in_valid && in_ready. in_idx is sampled only at that edge.
- in_ready = (state==IDLE) || (state==ACTIVE && cnt==1).
- Latency: for an accept at edge k, out = 1<<in_idx and out_valid=1 are visible after edge k and held for exactly HOLD cycles. They clear after edge k+HOLD unless a new accept happens at that edge.
- FSM IDLE:
  - accept with idx<N: out<=1<<idx, out_valid<=1, cnt<=HOLD, go ACTIVE.
  - accept with idx>=N: out stays 0, out_valid stays 0, err<=1 for one cycle, stay IDLE.
  - no accept: hold.
- FSM ACTIVE, cnt>1: cnt<=cnt-1. out is held. in_ready=0, so in_valid is ignored and in_idx may change freely.
- FSM ACTIVE, cnt==1:
  - accept with idx<N: reload out, out_valid=1, cnt<=HOLD, stay ACTIVE. Output is gapless; out may switch lines in a single edge.
  - accept with idx>=N: out<=0, out_valid<=0, err pulse, go IDLE.
  - no accept: out<=0, out_valid<=0, cnt<=0, go IDLE.
- HOLD=1: every ACTIVE cycle has cnt==1, so in_ready stays high constantly and a new index can be taken every cycle.
- err is cleared on every edge where no out-of-range accept occurs. It can only be 1 when N is not a power of two.
- Invariants:
  - out is one-hot when out_valid=1 and all-zero when out_valid=0.
  - out_valid == busy at all times.
- Arithmetic: cnt is an unsigned CW-bit counter and never wraps below 0. Comparisons of in_idx against N use at least M+1 bits.

Optional Feature:
- Macro THERMO_OUT_EN.
- Defined: an accepted idx<N loads out with a thermometer code, bits [idx:0] set (e.g. idx=2 gives 8'b0000_0111). This makes the block the inverse of "highest set bit" encoding. Timing, handshake and err are unchanged. The out_valid invariant becomes "out nonzero with bit 0 set".
- Undefined: one-hot as described above.
- Both builds are regression-tested.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1 and in_idx=3 -> out=0, out_valid=0, busy=0, in_ready=1, err=0. Release rst_n between edges -> the first edge accepts, and out=8'h08 for 4 cycles.
- Single pulse (N=8, HOLD=4): idx=5 with valid for one cycle -> out=8'h20 for exactly 4 cycles, in_ready=0 during the first 3 of those cycles, then IDLE.
- Back-to-back: in_valid held high with idx=1 then idx=6 presented when in_ready=1 -> out=8'h02 for 4 cycles, then 8'h40 for 4 cycles, with no zero cycle in between.
- Out of range (N=6, M=3): idx=7 accepted in IDLE -> err=1 for one cycle, out=0, out_valid=0. Repeat at cnt==1 during an active pulse -> the pulse ends, err pulses, state goes IDLE.
- HOLD=1, N=8: idx=0,1,2,3 on consecutive cycles with valid constant -> out=01,02,04,08 on consecutive cycles, in_ready stays 1, then out=0.
- THERMO_OUT_EN build: idx=3 -> out=8'h0F for HOLD cycles. Async reset asserted mid-pulse -> out=0 immediately.
